rs_issue_sched: RTL and testbench
=================================

RS_ISSUE_SCHED -- requirements
Module: rs_issue_sched

Interface
REQ-001 SHALL have parameter RS_LEN, 8, number of RS entries controlled (power of 2, >=2).
REQ-002 SHALL have one clock and synchronous active-high reset, ports named clock and reset.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 dispatch_valid  input  1  decoder presents an instruction for dispatch this cycle.
REQ-006 dispatch_stall  output  1  no allocatable entry; decoder holds its instruction.
REQ-007 entry_busy  input  RS_LEN  busy flag from each entry.
REQ-008 entry_ready  input  RS_LEN  operands-ready flag from each entry.
REQ-009 wr_en  output  RS_LEN  one-hot entry write enable.
REQ-010 clear  output  RS_LEN  per-entry clear, frees the entry next cycle.
REQ-011 squash  input  1  flush all entries and the issue slot.
REQ-012 issue_valid  output  1  registered; issue_idx names a valid instruction for the FU.
REQ-013 issue_idx  output  $clog2(RS_LEN)  registered index of the issued entry.
REQ-014 fu_ready  input  1  FU accepts the issue slot this cycle.
REQ-015 free_count  output  $clog2(RS_LEN)+1  number of entries with entry_busy=0.

Function
REQ-016 Candidate for allocation: entry_busy[i]=0; wr_en SHALL be one-hot on the lowest-index candidate when dispatch_valid=1 and squash=0, else all zero.
REQ-017 dispatch_stall SHALL be 1 exactly when no allocation candidate exists (combinational).
REQ-018 Issue candidate: entry_busy[i]=1, entry_ready[i]=1, and i is not the entry currently held in the issue slot.
REQ-019 Slot is open when issue_valid=0, or issue_valid=1 and fu_ready=1.
REQ-020 When the slot is open and a candidate exists, the selected index SHALL be registered into issue_idx with issue_valid=1 at the next edge; when open with no candidate, issue_valid SHALL go 0; when not open, issue_idx/issue_valid SHALL hold.
REQ-021 clear[issue_idx] SHALL be 1 exactly when issue_valid=1 and fu_ready=1 and squash=0; all other clear bits 0 except under squash.
REQ-022 An issued entry remains busy until accepted, so it is never reallocated while the FU may still read its packet.
REQ-023 Latency: dispatch at cycle t with operands ready -> busy/ready at t+1 -> issue_valid=1 at t+2 (empty slot assumed).
REQ-024 Back-to-back: accept at t and new selection at the same edge SHALL sustain one issue per cycle.
REQ-025 squash=1: clear SHALL be all ones, wr_en all zero, issue_valid SHALL be 0 at the next edge, age state reset; squash overrides fu_ready and dispatch_valid.
REQ-026 An entry cleared at cycle t SHALL be allocatable at t+1 (its busy drops at t+1).
REQ-027 free_count SHALL equal popcount(~entry_busy), combinational.

Reset
REQ-028 reset SHALL drive issue_valid=0, issue_idx=0 and all age state to 0 at the next edge; combinational outputs follow inputs.
REQ-029 reset mid-issue SHALL discard the slot without asserting clear; entries are reset separately.

Configuration
REQ-030 Macro RS_AGE_ORDER_EN defined: an RS_LEN x RS_LEN age matrix SHALL be kept; on allocation of k, row k is cleared and column k is set for all busy entries; selection picks the candidate older than all other candidates.
REQ-031 Macro RS_AGE_ORDER_EN undefined: no age state; selection picks the lowest-index candidate.

Verification (RS_LEN=4)
REQ-032 Reset, then dispatch_valid=1 with busy=0000 -> wr_en=0001, free_count=4, dispatch_stall=0.
REQ-033 busy=1111, dispatch_valid=1 -> wr_en=0000, dispatch_stall=1, free_count=0.
REQ-034 With RS_AGE_ORDER_EN: allocate entries 2 then 0, both ready, fu_ready=1 -> issue_idx=2 first, then 0 on the next cycle; without the macro -> 0 then 2.
REQ-035 Entry 1 issued, fu_ready=0 for 3 cycles -> issue_idx=1 held, clear=0000; fu_ready=1 -> clear=0010 for that cycle.
REQ-036 squash=1 with issue_valid=1, fu_ready=1, dispatch_valid=1 -> clear=1111, wr_en=0000, issue_valid=0 next cycle.
REQ-037 Entry 3 accepted at t (clear=1000), only free entry -> wr_en=1000 at t+1 when dispatch_valid=1.

Source files
------------

// File: rtl/rs_issue_sched.sv
// rs_issue_sched -- allocation and issue scheduler for a reservation station.
//
// Picks the entry that a dispatched instruction is written into, and picks
// which ready entry is handed to the functional unit through a one-deep
// registered issue slot. An issued entry stays busy until the FU accepts it;
// acceptance pulses that entry's clear bit so it frees on the next cycle.
//
// Build option:
//   RS_AGE_ORDER_EN  defined   -> oldest ready entry issues first (age matrix)
//                    undefined -> lowest-index ready entry issues first
//
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   dispatch_valid   decoder offers an instruction this cycle
//   dispatch_stall   no free entry; decoder must hold its instruction
//   entry_busy       per-entry busy flags
//   entry_ready      per-entry operands-ready flags
//   wr_en            one-hot write enable into the chosen free entry
//   clear            per-entry clear (accept, or all ones on squash)
//   squash           flush all entries and the issue slot
//   issue_valid      registered: issue_idx holds a valid instruction
//   issue_idx        registered index of the issued entry
//   fu_ready         FU accepts the issue slot this cycle
//   free_count       number of entries with entry_busy = 0
module rs_issue_sched #(
  parameter int RS_LEN = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        dispatch_valid,
  output logic                        dispatch_stall,
  input  logic [RS_LEN-1:0]           entry_busy,
  input  logic [RS_LEN-1:0]           entry_ready,
  output logic [RS_LEN-1:0]           wr_en,
  output logic [RS_LEN-1:0]           clear,
  input  logic                        squash,
  output logic                        issue_valid,
  output logic [$clog2(RS_LEN)-1:0]   issue_idx,
  input  logic                        fu_ready,
  output logic [$clog2(RS_LEN):0]     free_count
);

  localparam int IDX_W = $clog2(RS_LEN);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_LEN-1:0] alloc_cand;
  logic [RS_LEN-1:0] slot_mask;
  logic [RS_LEN-1:0] issue_cand;
  logic              alloc_found;
  logic              slot_open;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;

`ifdef RS_AGE_ORDER_EN
  // age[i][j] = 1 means entry i was allocated before entry j.
  logic [RS_LEN-1:0] age [RS_LEN];
  logic [IDX_W-1:0]  alloc_idx;
  logic              oldest;
`endif

  // Allocation: lowest-index free entry.
  always_comb begin
    alloc_cand  = ~entry_busy;
    alloc_found = 1'b0;
    wr_en       = '0;
`ifdef RS_AGE_ORDER_EN
    alloc_idx   = '0;
`endif
    for (int unsigned i = 0; i < RS_LEN; i++) begin
      if (alloc_cand[i] && !alloc_found) begin
        alloc_found = 1'b1;
        wr_en[i]    = dispatch_valid && !squash;
`ifdef RS_AGE_ORDER_EN
        alloc_idx   = i[IDX_W-1:0];
`endif
      end
    end
    dispatch_stall = !alloc_found;
  end

  always_comb begin
    free_count = '0;
    for (int unsigned i = 0; i < RS_LEN; i++)
      free_count = free_count + CNT_W'(alloc_cand[i]);
  end

  // The entry sitting in the slot stays busy and ready until accepted, so it
  // is masked out of selection to avoid issuing it twice.
  always_comb begin
    slot_mask  = issue_valid ? (RS_LEN'(1) << issue_idx) : '0;
    issue_cand = entry_busy & entry_ready & ~slot_mask;
    slot_open  = !issue_valid || fu_ready;
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef RS_AGE_ORDER_EN
    oldest    = 1'b0;
    for (int unsigned i = 0; i < RS_LEN; i++) begin
      if (issue_cand[i] && !sel_found) begin
        oldest = 1'b1;
        for (int unsigned j = 0; j < RS_LEN; j++)
          if (j != i && issue_cand[j] && !age[i][j]) oldest = 1'b0;
        if (oldest) begin
          sel_found = 1'b1;
          sel_idx   = i[IDX_W-1:0];
        end
      end
    end
`endif
    // Lowest-index pick; in age mode only a safety net for an inconsistent
    // matrix (e.g. entries marked busy without passing through wr_en).
    for (int unsigned i = 0; i < RS_LEN; i++) begin
      if (issue_cand[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = i[IDX_W-1:0];
      end
    end
  end

  // Accept-clear is suppressed under reset so a discarded slot never frees
  // an entry; squash clears everything regardless.
  always_comb begin
    clear = '0;
    if (squash)
      clear = '1;
    else if (issue_valid && fu_ready && !reset)
      clear = slot_mask;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_valid <= 1'b0;
      issue_idx   <= '0;
    end else if (squash) begin
      issue_valid <= 1'b0;
    end else if (slot_open) begin
      issue_valid <= sel_found;
      if (sel_found) issue_idx <= sel_idx;
    end
  end

`ifdef RS_AGE_ORDER_EN
  // New entry is younger than everything currently busy.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      for (int unsigned r = 0; r < RS_LEN; r++) age[r] <= '0;
    end else if (|wr_en) begin
      for (int unsigned r = 0; r < RS_LEN; r++) begin
        if (r == 32'(alloc_idx)) age[r] <= '0;
        else                     age[r][alloc_idx] <= entry_busy[r];
      end
    end
  end
`endif

endmodule

// File: tb/tb_rs_issue_sched.sv
// tb_rs_issue_sched -- self-checking bench for rs_issue_sched (RS_LEN = 4).
// The bench plays the role of the entries (busy/ready) and keeps a reference
// of the issue slot plus an allocation-order queue for age ordering.
module tb_rs_issue_sched;

  localparam int N = 4;

`ifdef RS_AGE_ORDER_EN
  localparam int AGE_FIRST  = 2;
  localparam int AGE_SECOND = 0;
`else
  localparam int AGE_FIRST  = 0;
  localparam int AGE_SECOND = 2;
`endif

  logic         clock;
  logic         reset;
  logic         dispatch_valid;
  logic         dispatch_stall;
  logic [N-1:0] entry_busy;
  logic [N-1:0] entry_ready;
  logic [N-1:0] wr_en;
  logic [N-1:0] clear;
  logic         squash;
  logic         issue_valid;
  logic [1:0]   issue_idx;
  logic         fu_ready;
  logic [2:0]   free_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [N-1:0] m_busy  = '0;
  logic [N-1:0] m_ready = '0;
  logic         m_valid = 1'b0;
  int           m_idx   = 0;
  int           order[$];   // busy entries, oldest first

  rs_issue_sched #(.RS_LEN(N)) dut (
    .clock          (clock),
    .reset          (reset),
    .dispatch_valid (dispatch_valid),
    .dispatch_stall (dispatch_stall),
    .entry_busy     (entry_busy),
    .entry_ready    (entry_ready),
    .wr_en          (wr_en),
    .clear          (clear),
    .squash         (squash),
    .issue_valid    (issue_valid),
    .issue_idx      (issue_idx),
    .fu_ready       (fu_ready),
    .free_count     (free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] c);
`ifdef RS_AGE_ORDER_EN
    foreach (order[q]) if (c[order[q]]) return order[q];
`endif
    for (int i = 0; i < N; i++) if (c[i]) return i;
    return -1;
  endfunction

  // One cycle: drive inputs after negedge, check 1 time unit later, then
  // advance the reference to what the next rising edge should produce.
  task automatic step(input logic dv, input logic sq, input logic fr,
                      input logic rst, input logic [N-1:0] mk);
    logic [N-1:0] exp_wr, exp_clr, icand, slot;
    int k, sel;
    @(negedge clock);
    m_ready        = m_ready | (mk & m_busy);
    dispatch_valid = dv;
    squash         = sq;
    fu_ready       = fr;
    reset          = rst;
    entry_busy     = m_busy;
    entry_ready    = m_ready;
    #1;
    k = -1;
    for (int i = 0; i < N; i++) if (!m_busy[i]) begin k = i; break; end
    exp_wr  = (dv && !sq && k >= 0) ? N'(1 << k) : '0;
    slot    = m_valid ? N'(1 << m_idx) : '0;
    exp_clr = sq ? '1 : ((m_valid && fr && !rst) ? slot : '0);
    chk("wr_en",          32'(wr_en),          32'(exp_wr));
    chk("dispatch_stall", 32'(dispatch_stall), 32'(k < 0));
    chk("free_count",     32'(free_count),     32'(N - $countones(m_busy)));
    chk("clear",          32'(clear),          32'(exp_clr));
    chk("issue_valid",    32'(issue_valid),    32'(m_valid));
    chk("issue_idx",      32'(issue_idx),      32'(m_idx));

    icand = m_busy & m_ready & ~slot;
    if (rst) begin
      m_valid = 1'b0; m_idx = 0; m_busy = '0; m_ready = '0; order.delete();
    end else if (sq) begin
      m_valid = 1'b0; m_busy = '0; m_ready = '0; order.delete();
    end else begin
      if (!m_valid || fr) begin
        sel     = pick(icand);
        m_valid = (sel >= 0);
        if (sel >= 0) m_idx = sel;
      end
      for (int i = 0; i < N; i++)
        if (exp_clr[i])
          for (int j = order.size() - 1; j >= 0; j--)
            if (order[j] == i) order.delete(j);
      m_busy  = m_busy & ~exp_clr;
      m_ready = m_ready & ~exp_clr;
      if (exp_wr != '0) begin
        m_busy[k] = 1'b1;
        order.push_back(k);
      end
    end
  endtask

  initial begin
    reset = 1'b1; dispatch_valid = 1'b0; squash = 1'b0; fu_ready = 1'b0;
    entry_busy = '0; entry_ready = '0;
    repeat (3) @(posedge clock);

    // Reset state and first allocation, then fill all entries
    step(1, 0, 0, 0, 4'b0000);           // wr 0001, free 4, no stall
    step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b0000);           // full: wr 0000, stall, free 0
    chk("full_stall", 32'(dispatch_stall), 32'd1);

    // Allocation order 2 then 0
    step(0, 0, 0, 1, 4'b0000);
    step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b0000);
    step(0, 0, 1, 0, 4'b0001);
    step(0, 0, 1, 0, 4'b0000);
    step(1, 0, 1, 0, 4'b0000);
    step(0, 0, 1, 0, 4'b0101);
    step(0, 0, 1, 0, 4'b0000);
    chk("order_first", 32'(issue_idx), 32'(AGE_FIRST));
    step(0, 0, 1, 0, 4'b0000);
    chk("order_second", 32'(issue_idx), 32'(AGE_SECOND));

    // Entry 1 held in the slot while the FU stalls
    step(0, 0, 1, 0, 4'b0010);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 0, 4'b0000);
      chk("hold_idx",   32'(issue_idx), 32'd1);
      chk("hold_clear", 32'(clear),     32'd0);
    end
    step(0, 0, 1, 0, 4'b0000);
    chk("accept_clear", 32'(clear), 32'b0010);

    // Squash beats accept and dispatch
    step(1, 0, 1, 0, 4'b0000);
    step(0, 0, 1, 0, 4'b0001);
    step(1, 1, 1, 0, 4'b0000);
    chk("squash_clear", 32'(clear), 32'hF);
    chk("squash_wr",    32'(wr_en), 32'h0);
    step(0, 0, 0, 0, 4'b0000);
    chk("squash_valid", 32'(issue_valid), 32'd0);

    // Entry 3 accepted while it is the only entry to free, then reallocated
    step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b0000);
    step(0, 0, 0, 0, 4'b1000);
    step(0, 0, 1, 0, 4'b0000);
    chk("last_clear", 32'(clear), 32'b1000);
    step(1, 0, 0, 0, 4'b0000);
    chk("realloc_wr", 32'(wr_en), 32'b1000);

    // Reset while the slot is valid and accepted: no clear
    step(0, 0, 0, 0, 4'b1000);
    step(0, 0, 1, 1, 4'b0000);
    chk("reset_noclear", 32'(clear), 32'd0);
    step(0, 0, 1, 0, 4'b0000);
    chk("reset_valid", 32'(issue_valid), 32'd0);

    // Randomized traffic against the reference
    for (int c = 0; c < 600; c++) begin
      step(($urandom % 4) != 0, ($urandom % 40) == 0, ($urandom % 4) != 0,
           ($urandom % 80) == 0, N'($urandom & $urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
